// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Single-outstanding instruction-fetch responder backed by a
//               preloadable word memory, with a fixed response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter int Address_Width = 32,
  parameter int Data_Width    = 32,
  parameter int Mem_Depth     = 1024,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_Req_Valid,
  input  logic [Address_Width-1:0] i_Req_Addr,
  output logic                     o_Req_Ready,
  output logic                     o_Rsp_Valid,
  output logic [Data_Width-1:0]    o_Rsp_Instr,
  output logic                     o_Rsp_Err,
  input  logic                     i_Rsp_Ready,
  input  logic                     i_Flush,
  input  logic                     i_Wr_En,
  input  logic [Address_Width-1:0] i_Wr_Addr,
  input  logic [Data_Width-1:0]    i_Wr_Data
);

  localparam int c_IDX_W  = Address_Width - 2;
  localparam int c_MEM_AW = (Mem_Depth > 1) ? $clog2(Mem_Depth) : 1;
  localparam logic [Data_Width-1:0] c_NOP  = Data_Width'(32'h00000013);
  localparam logic [3:0]            c_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                   r_state;
  logic [3:0]               r_cnt;
  logic [Address_Width-1:0] r_addr;
  logic [Data_Width-1:0]    r_mem [Mem_Depth];

  logic                     w_accept;
  logic [Address_Width-1:0] w_cap_addr;
  logic [c_IDX_W-1:0]       w_cap_idx;
  logic                     w_cap_ok;
  logic [Data_Width-1:0]    w_cap_data;
  logic [c_IDX_W-1:0]       w_wr_idx;
  logic                     w_wr_ok;
  logic                     w_unused_wr_lsb;

  function automatic logic idx_in_range(input logic [c_IDX_W-1:0] idx);
    return {{(64-c_IDX_W){1'b0}}, idx} < 64'(Mem_Depth);
  endfunction

  assign o_Req_Ready = !i_Flush &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && i_Rsp_Ready));
  assign w_accept    = i_Req_Valid && o_Req_Ready;

  // Capture source: the latched address while waiting, otherwise the incoming
  // request (zero-latency responses are captured at the acceptance edge).
  assign w_cap_addr = (r_state == S_WAIT) ? r_addr : i_Req_Addr;
  assign w_cap_idx  = w_cap_addr[Address_Width-1:2];
  assign w_cap_ok   = (w_cap_addr[1:0] == 2'b00) && idx_in_range(w_cap_idx);
  assign w_cap_data = r_mem[w_cap_idx[c_MEM_AW-1:0]];

  assign w_wr_idx        = i_Wr_Addr[Address_Width-1:2];
  assign w_wr_ok         = i_Wr_En && idx_in_range(w_wr_idx);
  assign w_unused_wr_lsb = &{1'b0, i_Wr_Addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      o_Rsp_Valid <= 1'b0;
      o_Rsp_Instr <= '0;
      o_Rsp_Err   <= 1'b0;
    end else if (i_Flush) begin
      r_state     <= S_IDLE;
      o_Rsp_Valid <= 1'b0;
    end else if (w_accept) begin
      r_addr <= i_Req_Addr;
      r_cnt  <= c_WAIT;
      if (c_WAIT == 4'd0) begin
        r_state     <= S_RESP;
        o_Rsp_Valid <= 1'b1;
        o_Rsp_Instr <= w_cap_ok ? w_cap_data : c_NOP;
        o_Rsp_Err   <= !w_cap_ok;
      end else begin
        r_state     <= S_WAIT;
        o_Rsp_Valid <= 1'b0;
      end
    end else begin
      case (r_state)
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            o_Rsp_Valid <= 1'b1;
            o_Rsp_Instr <= w_cap_ok ? w_cap_data : c_NOP;
            o_Rsp_Err   <= !w_cap_ok;
          end
        end
        S_RESP: begin
          if (i_Rsp_Ready) begin
            r_state     <= S_IDLE;
            o_Rsp_Valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          o_Rsp_Valid <= 1'b0;
        end
      endcase
    end
  end

  // Memory is deliberately outside the reset domain so preloads survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_idx[c_MEM_AW-1:0]] <= i_Wr_Data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Three responders (latency 0/1/3) on shared stimulus, checked
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;
  localparam int N     = 3;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr  = '0;
  logic        rsp_ready = 1'b0;
  logic        flush     = 1'b0;
  logic        wr_en     = 1'b0;
  logic [31:0] wr_addr   = '0;
  logic [31:0] wr_data   = '0;

  logic [N-1:0] req_ready, rsp_valid, rsp_err;
  logic [31:0]  rsp_instr [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    imem_responder #(
      .Address_Width(32),
      .Data_Width   (32),
      .Mem_Depth    (DEPTH),
      .WAIT_CYCLES  ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_Req_Valid(req_valid),
      .i_Req_Addr (req_addr),
      .o_Req_Ready(req_ready[g]),
      .o_Rsp_Valid(rsp_valid[g]),
      .o_Rsp_Instr(rsp_instr[g]),
      .o_Rsp_Err  (rsp_err[g]),
      .i_Rsp_Ready(rsp_ready),
      .i_Flush    (flush),
      .i_Wr_En    (wr_en),
      .i_Wr_Addr  (wr_addr),
      .i_Wr_Data  (wr_data)
    );
  end

  // Reference model: an outstanding request is due a fixed number of edges
  // after acceptance; the memory is a plain word array.
  int          wv [N] = '{0, 1, 3};
  bit          m_busy  [N];
  bit          m_valid [N];
  int          m_due   [N];
  logic [31:0] m_addr  [N];
  logic [31:0] m_instr [N];
  bit          m_err   [N];
  logic [31:0] m_mem   [DEPTH];
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int k);
    return !flush && (!m_busy[k] || (m_valid[k] && rsp_ready));
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < N; k++) begin
      m_busy[k]  = 0;
      m_valid[k] = 0;
      m_instr[k] = '0;
      m_err[k]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      bit rdy;
      rdy = m_ready(k);
      if (flush) begin
        m_busy[k]  = 0;
        m_valid[k] = 0;
      end else begin
        if (m_valid[k] && rsp_ready) begin
          m_valid[k] = 0;
          m_busy[k]  = 0;
        end
        if (req_valid && rdy) begin
          m_busy[k] = 1;
          m_addr[k] = req_addr;
          m_due[k]  = cyc + wv[k];
        end
        if (m_busy[k] && !m_valid[k] && cyc == m_due[k]) begin
          m_valid[k] = 1;
          m_err[k]   = addr_bad(m_addr[k]);
          m_instr[k] = m_err[k] ? NOP : m_mem[m_addr[k][31:2]];
        end
      end
    end
    if (wr_en && wr_addr[31:2] < DEPTH) m_mem[wr_addr[31:2]] = wr_data;
    cyc++;
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic step();
    #1;
    for (int k = 0; k < N; k++)
      check($sformatf("req_ready[%0d]", k), req_ready[k], m_ready(k));
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rsp_valid[%0d]", k), rsp_valid[k], m_valid[k]);
      if (m_valid[k]) begin
        check($sformatf("rsp_instr[%0d]", k), rsp_instr[k], m_instr[k]);
        check($sformatf("rsp_err[%0d]", k), rsp_err[k], m_err[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    req_valid = 0;
    flush     = 0;
    rsp_ready = 1;
    wr_en     = 0;
    repeat (n) step();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, rsp_valid, 3'b000);
    check({tag, "_err"}, rsp_err, 3'b000);
    for (int k = 0; k < N; k++) check($sformatf("%s_instr[%0d]", tag, k), rsp_instr[k], 32'h0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 0;

    // Preload words 0..63; low address bits are junk and must be ignored.
    for (int i = 0; i < 64; i++) begin
      wr_en   = 1;
      wr_addr = 32'(i * 4) | 32'(i % 4);
      wr_data = (i == 4) ? 32'h00500093 : $urandom;
      step();
    end
    wr_en = 0;
    check("idle_ready", req_ready, 3'b111);

    // Single fetch at latency 1.
    req_valid = 1; req_addr = 32'h10; rsp_ready = 1;
    step();
    check("lat1_e0_valid", rsp_valid[1], 1'b0);
    req_valid = 0;
    step();
    check("lat1_e1_valid", rsp_valid[1], 1'b1);
    check("lat1_e1_instr", rsp_instr[1], 32'h00500093);
    check("lat1_e1_err", rsp_err[1], 1'b0);
    step();
    check("lat1_e2_valid", rsp_valid[1], 1'b0);
    drain(4);

    // Back-to-back at latency 0.
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_addr = 32'(i * 4);
      step();
      check("b2b_valid", rsp_valid[0], 1'b1);
      check("b2b_instr", rsp_instr[0], m_mem[i]);
    end
    req_valid = 0;
    step();
    check("b2b_end_valid", rsp_valid[0], 1'b0);
    drain(4);

    // Consumer stall: response must hold, no new request accepted.
    req_valid = 1; req_addr = 32'h14; rsp_ready = 0;
    step();
    req_addr = 32'h18;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", rsp_valid[0], 1'b1);
      check("stall_instr", rsp_instr[0], m_mem[5]);
      check("stall_err", rsp_err[0], 1'b0);
      check("stall_ready", req_ready[0], 1'b0);
    end
    rsp_ready = 1;
    step();
    check("stall_next_instr", rsp_instr[0], m_mem[6]);
    drain(5);

    // Misaligned and out-of-range fetches.
    req_valid = 1; req_addr = 32'h6;
    step();
    check("misalign_err", rsp_err[0], 1'b1);
    check("misalign_instr", rsp_instr[0], NOP);
    req_addr = 32'h1000;
    step();
    check("oor_err", rsp_err[0], 1'b1);
    check("oor_instr", rsp_instr[0], NOP);
    drain(5);

    // Flush one cycle after acceptance at latency 3.
    req_valid = 1; req_addr = 32'h20;
    step();
    req_valid = 0; flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("flushed_valid", rsp_valid[2], 1'b0);
    end
    req_valid = 1; req_addr = 32'h24;
    step();
    req_valid = 0;
    step();
    step();
    check("post_flush_e2_valid", rsp_valid[2], 1'b0);
    step();
    check("post_flush_e3_valid", rsp_valid[2], 1'b1);
    check("post_flush_instr", rsp_instr[2], m_mem[9]);
    drain(5);

    // Asynchronous reset while holding a response.
    req_valid = 1; req_addr = 32'h10; rsp_ready = 0;
    step();
    req_valid = 0;
    step();
    check("pre_rst_valid", rsp_valid[1], 1'b1);
    #2;
    rst = 1;
    #1;
    check_zero_outputs("async_rst");
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    rsp_ready = 1; req_valid = 1; req_addr = 32'h10;
    step();
    check("post_rst_instr0", rsp_instr[0], 32'h00500093);
    check("post_rst_valid0", rsp_valid[0], 1'b1);
    req_valid = 0;
    step();
    check("post_rst_instr1", rsp_instr[1], 32'h00500093);
    drain(5);

    // Randomised traffic.
    repeat (400) begin
      int r;
      r = int'($urandom_range(0, 19));
      req_valid = ($urandom_range(0, 3) != 0);
      if (r < 16)      req_addr = 32'($urandom_range(0, 63) * 4);
      else if (r < 18) req_addr = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
      else             req_addr = 32'h1000 + 32'($urandom_range(0, 63) * 4);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      wr_en     = ($urandom_range(0, 4) == 0);
      wr_addr   = 32'($urandom_range(16, 63) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) wr_addr = wr_addr | 32'h1000;
      wr_data   = $urandom;
      step();
    end
    drain(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
